// File: rtl/display_digit_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Package : display_pkg -- shared constants and types for the display blocks
// Rev     : 1.0
// ============================================================================
package display_pkg;

  localparam int ACT_LOW  = 1;
  localparam int ACT_HIGH = 0;

  localparam int DEFAULT_N_DIGITS    = 4;
  localparam int DEFAULT_REFRESH_DIV = 50000;

  typedef logic [3:0] digit_nibble_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_digit_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface : display_digit_scanner_if -- control/value inputs, scan outputs
// Rev       : 1.0
// ============================================================================
interface display_digit_scanner_if
  import display_pkg::*;
#(
  parameter int N_DIGITS = DEFAULT_N_DIGITS
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  en;
  logic                  load;
  logic [4*N_DIGITS-1:0] value_i;
  logic                  blank_lz;
  digit_nibble_t         digit_o;
  logic [N_DIGITS-1:0]   anode_o;
  logic [IDX_W-1:0]      digit_idx_o;
  logic                  frame_done;

  modport master (
    output en, load, value_i, blank_lz,
    input  digit_o, anode_o, digit_idx_o, frame_done
  );

  modport slave (
    input  en, load, value_i, blank_lz,
    output digit_o, anode_o, digit_idx_o, frame_done
  );

endinterface : display_digit_scanner_if
`default_nettype wire

// File: rtl/display_digit_scanner_prescaler.sv
`default_nettype none
// ============================================================================
// Module : refresh_prescaler -- free-running 0..DIV-1 counter, tick on last
// Rev    : 1.0
// ============================================================================
module refresh_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int              CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == C_LAST) ? '0 : r_count + CW'(1);
    end
  end

  assign tick = en && (r_count == C_LAST);

endmodule : refresh_prescaler
`default_nettype wire

// File: rtl/display_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module : display_digit_scanner -- multiplexed 7-seg digit scan driver
// Rev    : 1.0
// ============================================================================
module display_digit_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS      = DEFAULT_N_DIGITS,
  parameter int REFRESH_DIV   = DEFAULT_REFRESH_DIV,
  parameter int ANODE_ACT_LOW = ACT_LOW
) (
  input  logic                    clk,
  input  logic                    rst,
  display_digit_scanner_if.slave  bus
);
  localparam int               IW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int               VW         = 4 * N_DIGITS;
  localparam logic [IW-1:0]    C_LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic             C_OFF      = (ANODE_ACT_LOW == ACT_HIGH) ? 1'b0 : 1'b1;
  localparam logic [N_DIGITS-1:0] C_ALL_OFF = {N_DIGITS{C_OFF}};

  logic                w_tick;
  logic                w_wrap;
  logic                w_blank;
  logic [VW-1:0]       w_upper;
  logic [N_DIGITS-1:0] w_sel;

  logic [IW-1:0]       r_idx;
  logic [VW-1:0]       r_shadow;
  logic [VW-1:0]       r_pending;
  logic                r_pending_valid;

  digit_nibble_t       r_digit;
  logic [N_DIGITS-1:0] r_anode;
  logic [IW-1:0]       r_idx_o;
  logic                r_frame_done;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (w_tick)
  );

  assign w_wrap  = w_tick && (r_idx == C_LAST_IDX);
  // Shifting the selected nibble down to bit 0 leaves only it and the more
  // significant nibbles, so a zero result means "this and all leading are 0".
  assign w_upper = r_shadow >> {r_idx, 2'b00};
  assign w_blank = bus.blank_lz && (r_idx != '0) && (w_upper == '0);
  assign w_sel   = N_DIGITS'(1) << r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx           <= '0;
      r_shadow        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else begin
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      end
      // Shadow only changes at the frame boundary so a frame never mixes values.
      if (w_wrap) begin
        if (bus.load) begin
          r_shadow <= bus.value_i;
        end else if (r_pending_valid) begin
          r_shadow <= r_pending;
        end
        r_pending_valid <= 1'b0;
      end else if (bus.load) begin
        r_pending       <= bus.value_i;
        r_pending_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit      <= '0;
      r_anode      <= C_ALL_OFF;
      r_idx_o      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_idx_o      <= r_idx;
      r_frame_done <= w_wrap;
      if (!bus.en) begin
        r_anode <= C_ALL_OFF;
      end else if (w_blank) begin
        r_anode <= C_ALL_OFF;
        r_digit <= '0;
      end else begin
        r_anode <= C_OFF ? ~w_sel : w_sel;
        r_digit <= w_upper[3:0];
      end
    end
  end

  assign bus.digit_o     = r_digit;
  assign bus.anode_o     = r_anode;
  assign bus.digit_idx_o = r_idx_o;
  assign bus.frame_done  = r_frame_done;

endmodule : display_digit_scanner
`default_nettype wire

// File: tb/tb_display_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_display_digit_scanner -- self-checking bench for the scanner
// Rev    : 1.0
// ============================================================================
module tb_display_digit_scanner;
  import display_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  display_digit_scanner_if #(.N_DIGITS(N)) bus ();

  display_digit_scanner #(
    .N_DIGITS      (N),
    .REFRESH_DIV   (DIV),
    .ANODE_ACT_LOW (ACT_LOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: position in the scan derives from the total enabled cycle count.
  int          m_ecnt;
  logic [15:0] m_shadow, m_pend;
  bit          m_pv;
  logic [3:0]  e_digit, e_anode;
  logic [1:0]  e_idx;
  logic        e_fd;

  typedef struct {
    logic [15:0] val;
    logic        blz;
    logic [15:0] dig;
    logic [15:0] an;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ecnt = 0; m_shadow = '0; m_pend = '0; m_pv = 0;
    e_digit = '0; e_anode = 4'hF; e_idx = '0; e_fd = 1'b0;
  endtask

  task automatic model_step(input logic ien, input logic iload,
                            input logic [15:0] ival, input logic iblz);
    int          idx;
    bit          tick, wrap;
    logic [15:0] upper;
    idx   = (m_ecnt / DIV) % N;
    tick  = ien && ((m_ecnt % DIV) == DIV - 1);
    wrap  = tick && (idx == N - 1);
    upper = m_shadow >> (4 * idx);
    e_idx = idx[1:0];
    e_fd  = wrap;
    if (!ien) begin
      e_anode = 4'hF;
    end else if (iblz && idx > 0 && upper == 16'h0) begin
      e_anode = 4'hF;
      e_digit = 4'h0;
    end else begin
      e_anode = 4'(~(4'b0001 << idx));
      e_digit = upper[3:0];
    end
    if (wrap) begin
      if (iload) m_shadow = ival;
      else if (m_pv) m_shadow = m_pend;
      m_pv = 0;
    end else if (iload) begin
      m_pend = ival;
      m_pv   = 1;
    end
    if (ien) m_ecnt++;
  endtask

  // Starts and ends at a falling edge; compares DUT against the model.
  task automatic cycle(input logic ien, input logic iload, input logic [15:0] ival,
                       input logic iblz, input logic irst);
    bus.en = ien; bus.load = iload; bus.value_i = ival; bus.blank_lz = iblz;
    rst = irst;
    if (irst) model_reset();
    @(posedge clk);
    if (!irst) model_step(ien, iload, ival, iblz);
    @(negedge clk);
    chk("model_digit", bus.digit_o, e_digit);
    chk("model_anode", bus.anode_o, e_anode);
    chk("model_idx", bus.digit_idx_o, e_idx);
    chk("model_frame_done", bus.frame_done, e_fd);
  endtask

  task automatic wait_fd(input logic iblz);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b1, 1'b0, 16'h0, iblz, 1'b0);
      if (bus.frame_done) seen = 1;
    end
    if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit found;
    int n;
    bit seen;

    tbl[0] = '{val: 16'h0050, blz: 1'b1, dig: 16'h0050, an: 16'hFFDE};
    tbl[1] = '{val: 16'h0050, blz: 1'b0, dig: 16'h0050, an: 16'h7BDE};
    tbl[2] = '{val: 16'h0000, blz: 1'b1, dig: 16'h0000, an: 16'hFFFE};
    tbl[3] = '{val: 16'hF00A, blz: 1'b1, dig: 16'hF00A, an: 16'h7BDE};
    tbl[4] = '{val: 16'h0100, blz: 1'b1, dig: 16'h0100, an: 16'hFBDE};
    tbl[5] = '{val: 16'h1234, blz: 1'b0, dig: 16'h1234, an: 16'h7BDE};

    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.value_i = '0; bus.blank_lz = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_anode", bus.anode_o, 4'hF);
    chk("rst_digit", bus.digit_o, 4'h0);
    chk("rst_frame_done", bus.frame_done, 1'b0);

    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_anode", bus.anode_o, 4'hF);
    chk("async_rst_digit", bus.digit_o, 4'h0);
    chk("async_rst_idx", bus.digit_idx_o, 2'd0);
    chk("async_rst_frame_done", bus.frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    found = 0; n = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      if (bus.digit_idx_o == 2'd1) begin found = 1; n = i; end
    end
    chk("first_tick_cycle", n, 5);

    foreach (tbl[t]) begin
      cycle(1'b1, 1'b1, tbl[t].val, tbl[t].blz, 1'b0);
      if (!bus.frame_done) wait_fd(tbl[t].blz);
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          cycle(1'b1, 1'b0, 16'h0, tbl[t].blz, 1'b0);
          chk("tbl_digit", bus.digit_o, tbl[t].dig[4*k +: 4]);
          chk("tbl_anode", bus.anode_o, tbl[t].an[4*k +: 4]);
          chk("tbl_idx", bus.digit_idx_o, k);
          chk("tbl_frame_done", bus.frame_done, (k == 3 && j == 3));
        end
      end
    end

    // Tear-free: load mid-frame while 1234 is being shown
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      if (bus.digit_idx_o == 2'd2) found = 1;
    end
    chk("tear_reach_idx2", found, 1);
    cycle(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      if (seen) begin
        chk("tear_new_digit0", bus.digit_o, 4'hD);
        chk("tear_new_idx0", bus.digit_idx_o, 2'd0);
        break;
      end
      if (bus.digit_idx_o == 2'd2) chk("tear_old_digit2", bus.digit_o, 4'h2);
      if (bus.digit_idx_o == 2'd3) chk("tear_old_digit3", bus.digit_o, 4'h1);
      if (bus.frame_done) seen = 1;
    end
    chk("tear_wrap_seen", seen, 1);

    // Load landing exactly on the wrap tick
    wait_fd(1'b0);
    repeat (15) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0);
    chk("sim_frame_done", bus.frame_done, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("sim_digit0", bus.digit_o, 4'h0);
    chk("sim_idx0", bus.digit_idx_o, 2'd0);
    repeat (4) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("sim_digit1", bus.digit_o, 4'hF);
    chk("sim_idx1", bus.digit_idx_o, 2'd1);

    // Enable gap while digit 1 is selected
    repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("gap_anode_dark", bus.anode_o, 4'hF);
      chk("gap_no_frame_done", bus.frame_done, 1'b0);
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("gap_resume_idx", bus.digit_idx_o, 2'd1);
    chk("gap_resume_anode", bus.anode_o, 4'hD);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h00FF;
        2:       mask = 16'h000F;
        default: mask = 16'h0F00;
      endcase
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
            16'($urandom) & mask, 1'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_display_digit_scanner
`default_nettype wire
